// File: rtl/opb_register_simulink2ppc_snap.sv
// rtl/opb_register_simulink2ppc_snap.sv - OPB slave publishing a fabric data word, capture status and freeze control to the PPC
module opb_register_simulink2ppc_snap #(
   parameter logic [31:0] C_BASEADDR   = 32'h0108D600,
   parameter logic [31:0] C_HIGHADDR   = 32'h0108D6FF,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter              C_FAMILY     = "virtex5"
) (
   input  logic                      OPB_Clk,
   input  logic                      OPB_Rst,
   input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
   input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
   input  logic                      OPB_RNW,
   input  logic                      OPB_select,
   input  logic                      OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
   output logic                      Sl_xferAck,
   output logic                      Sl_errAck,
   output logic                      Sl_retry,
   output logic                      Sl_toutSup,
   input  logic [31:0]               user_data_in,
   input  logic                      user_data_valid
);

   typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

   localparam logic [1:0] IDX_DATA   = 2'd0;
   localparam logic [1:0] IDX_STATUS = 2'd1;
   localparam logic [1:0] IDX_CTRL   = 2'd2;

   state_t      state;
   logic [31:0] data;
   logic [15:0] cnt;
   logic        new_flag;
   logic        ovr;
   logic        freeze;
   logic [1:0]  sel_idx;
   logic        sel_rnw;
   logic        hit;
   logic        capture;
   logic        status_clr;
   logic        ctrl_wr;
   logic [31:0] rd_word;
   logic        unused;

   assign hit = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
   assign capture = user_data_valid && !freeze;
   assign status_clr = (state == ACK) && sel_rnw && (sel_idx == IDX_STATUS);
   assign ctrl_wr = (state == ACK) && !sel_rnw && (sel_idx == IDX_CTRL) && OPB_BE[3];

   assign Sl_errAck  = 1'b0;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;

   assign unused = &{1'b0, OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:30], ^C_FAMILY};

   always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
      if (!OPB_Rst) begin
         data     <= '0;
         cnt      <= '0;
         new_flag <= 1'b0;
         ovr      <= 1'b0;
         freeze   <= 1'b0;
      end else begin
         if (capture) begin
            data <= user_data_in;
            cnt  <= cnt + 16'd1;
         end
         // A capture landing on the clearing edge keeps NEW but still drops OVR
         if (status_clr) begin
            new_flag <= capture;
            ovr      <= 1'b0;
         end else if (capture) begin
            ovr      <= ovr | new_flag;
            new_flag <= 1'b1;
         end
         if (ctrl_wr) begin
            freeze <= OPB_DBus[31];
         end
      end
   end

   always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
      if (!OPB_Rst) begin
         state      <= IDLE;
         Sl_xferAck <= 1'b0;
         sel_idx    <= 2'd0;
         sel_rnw    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (hit) begin
                  state      <= ACK;
                  Sl_xferAck <= 1'b1;
                  sel_idx    <= OPB_ABus[28:29];
                  sel_rnw    <= OPB_RNW;
               end
            end
            ACK: begin
               Sl_xferAck <= 1'b0;
               state      <= OPB_select ? HOLD : IDLE;
            end
            HOLD: begin
               if (!OPB_select) begin
                  state <= IDLE;
               end
            end
            default: begin
               state      <= IDLE;
               Sl_xferAck <= 1'b0;
            end
         endcase
      end
   end

   // Read mux is gated by the registered acknowledge so the bus stays zero otherwise
   always_comb begin
      rd_word = '0;
      if (Sl_xferAck && sel_rnw) begin
         case (sel_idx)
            IDX_DATA:   rd_word = data;
            IDX_STATUS: rd_word = {new_flag, ovr, 14'd0, cnt};
            IDX_CTRL:   rd_word = {31'd0, freeze};
            default:    rd_word = '0;
         endcase
      end
   end

   assign Sl_DBus = rd_word;

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// tb/tb_opb_register_simulink2ppc_snap.sv - scoreboard bench for the Simulink-to-PPC snapshot register
module tb_opb_register_simulink2ppc_snap;

   localparam logic [31:0] BASE = 32'h0108D600;
   localparam logic [31:0] HIGH = 32'h0108D6FF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] OPB_ABus = '0;
   logic [3:0]  OPB_BE = '0;
   logic [31:0] OPB_DBus = '0;
   logic        OPB_RNW = 1'b0;
   logic        OPB_select = 1'b0;
   logic        OPB_seqAddr = 1'b0;
   logic [31:0] Sl_DBus;
   logic        Sl_xferAck;
   logic        Sl_errAck;
   logic        Sl_retry;
   logic        Sl_toutSup;
   logic [31:0] user_data_in = '0;
   logic        user_data_valid = 1'b0;

   opb_register_simulink2ppc_snap dut (
      .OPB_Clk         (clk),
      .OPB_Rst         (rst_n),
      .OPB_ABus        (OPB_ABus),
      .OPB_BE          (OPB_BE),
      .OPB_DBus        (OPB_DBus),
      .OPB_RNW         (OPB_RNW),
      .OPB_select      (OPB_select),
      .OPB_seqAddr     (OPB_seqAddr),
      .Sl_DBus         (Sl_DBus),
      .Sl_xferAck      (Sl_xferAck),
      .Sl_errAck       (Sl_errAck),
      .Sl_retry        (Sl_retry),
      .Sl_toutSup      (Sl_toutSup),
      .user_data_in    (user_data_in),
      .user_data_valid (user_data_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] word;
      int          due;
      string       name;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   bit   end_req = 1'b0;
   bit   rand_cap = 1'b0;
   int   ack_kind = 0;
   bit   wr_bit = 1'b0;

   // Reference state: what the PPC should see, kept as plain values
   logic [31:0] m_data;
   int          m_cnt;
   bit          m_new;
   bit          m_ovr;
   bit          m_freeze;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_data = '0; m_cnt = 0; m_new = 0; m_ovr = 0; m_freeze = 0;
      end else begin
         bit cap;
         cap = user_data_valid && !m_freeze;
         if (cap) begin
            m_data = user_data_in;
            m_cnt  = (m_cnt + 1) % 65536;
         end
         if (ack_kind == 1) begin
            m_new = cap;
            m_ovr = 0;
         end else if (cap) begin
            m_ovr = m_ovr || m_new;
            m_new = 1;
         end
         if (ack_kind == 2) m_freeze = wr_bit;
      end
   end

   function automatic logic [31:0] exp_word(input logic [1:0] idx);
      logic [15:0] c;
      c = 16'(m_cnt);
      case (idx)
         2'd0:    return m_data;
         2'd1:    return {m_new, m_ovr, 14'd0, c};
         2'd2:    return {31'd0, m_freeze};
         default: return 32'd0;
      endcase
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         total++;
         if (Sl_xferAck !== 1'b0 || Sl_DBus !== 32'd0) begin
            bad++;
            $display("FAIL rst_out ack=%b dbus=%h required ack=0 dbus=0", Sl_xferAck, Sl_DBus);
         end
      end else begin
         if (q.size() > 0 && q[0].due < cyc) begin
            exp_t m;
            m = q.pop_front();
            total++; bad++;
            $display("FAIL missing_ack %s at cycle %0d: no acknowledge, required one at cycle %0d", m.name, cyc, m.due);
         end
         if (Sl_xferAck) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_ack cycle=%0d dbus=%h required no acknowledge", cyc, Sl_DBus);
            end else begin
               exp_t e;
               e = q.pop_front();
               if (Sl_DBus !== e.word || e.due != cyc) begin
                  bad++;
                  $display("FAIL %s got=%h@%0d required=%h@%0d", e.name, Sl_DBus, cyc, e.word, e.due);
               end
            end
         end
      end
      if (cyc > 90000) begin
         $display("FAIL watchdog cycle=%0d limit=90000", cyc);
         $fatal(1, "watchdog");
      end
      if (end_req) begin
         total++;
         if (q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expect got=%0d required=0", q.size());
         end
         $display("test done: total=%0d bad=%0d", total, bad);
         $finish;
      end
   end

   task automatic tick();
      @(negedge clk);
      if (rand_cap) begin
         user_data_valid = 1'($urandom_range(0, 1));
         user_data_in    = $urandom;
      end
   endtask

   task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [31:0] wd,
                       input logic [3:0] be, input int hold, input bit cap_ack, input string nm);
      bit          hit;
      logic [1:0]  idx;
      exp_t        e;
      tick();
      OPB_ABus = addr; OPB_RNW = rnw; OPB_DBus = wd; OPB_BE = be; OPB_select = 1'b1;
      hit = (addr >= BASE) && (addr <= HIGH);
      idx = addr[3:2];
      @(posedge clk); #1;
      if (hit) begin
         e.word = rnw ? exp_word(idx) : 32'd0;
         e.due  = cyc;
         e.name = nm;
         q.push_back(e);
         if (rnw && idx == 2'd1) ack_kind = 1;
         else if (!rnw && idx == 2'd2 && be[0]) begin
            ack_kind = 2;
            wr_bit   = wd[0];
         end
      end
      tick();
      if (cap_ack) begin
         user_data_valid = 1'b1;
         user_data_in    = $urandom;
      end
      if (hold == 0) OPB_select = 1'b0;
      @(posedge clk); #1;
      ack_kind = 0;
      if (cap_ack) user_data_valid = 1'b0;
      if (hold > 0) begin
         repeat (hold) tick();
         tick();
         OPB_select = 1'b0;
      end
   endtask

   task automatic rd(input logic [1:0] idx, input string nm);
      xfer(BASE + {28'd0, idx, 2'b00}, 1'b1, 32'd0, 4'hF, 0, 1'b0, nm);
   endtask

   task automatic cap(input logic [31:0] d);
      tick();
      user_data_valid = 1'b1;
      user_data_in    = d;
      tick();
      user_data_valid = 1'b0;
   endtask

   task automatic do_reset();
      tick();
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
   endtask

   initial begin
      repeat (3) tick();
      rst_n = 1'b1;
      rd(2'd0, "rst_data"); rd(2'd1, "rst_status"); rd(2'd2, "rst_ctrl");

      cap(32'hDEADBEEF);
      rd(2'd0, "data_deadbeef"); rd(2'd1, "status_new"); rd(2'd1, "status_cleared");

      cap(32'h1); cap(32'h2); cap(32'h3);
      rd(2'd1, "status_ovr"); rd(2'd1, "status_ovr_cleared");

      xfer(BASE + 32'h8, 1'b0, 32'h1, 4'b0001, 0, 1'b0, "wr_freeze");
      cap(32'h12345678);
      rd(2'd0, "frozen_data"); rd(2'd1, "frozen_status");
      xfer(BASE + 32'h8, 1'b0, 32'h0, 4'b1110, 0, 1'b0, "wr_ctrl_nobe");
      rd(2'd2, "ctrl_still_frozen");
      xfer(BASE + 32'h0, 1'b0, 32'hFFFFFFFF, 4'hF, 0, 1'b0, "wr_data_ignored");
      xfer(BASE + 32'h8, 1'b0, 32'h0, 4'b0001, 1, 1'b0, "wr_unfreeze_hold");
      rd(2'd0, "data_after_ignored_wr");

      cap(32'hA5A5A5A5);
      xfer(BASE + 32'h4, 1'b1, 32'd0, 4'hF, 0, 1'b1, "status_cap_in_ack");
      rd(2'd1, "status_after_cap_in_ack");
      rd(2'd3, "reserved_rd");
      xfer(BASE - 32'h4, 1'b1, 32'd0, 4'hF, 0, 1'b0, "miss_below");
      xfer(HIGH + 32'h1, 1'b1, 32'd0, 4'hF, 0, 1'b0, "miss_above");

      rand_cap = 1'b1;
      for (int i = 0; i < 60; i++) begin
         logic [31:0] a;
         int          sel;
         sel = int'($urandom_range(0, 9));
         if (sel == 0)      a = BASE - 32'h4;
         else if (sel == 1) a = HIGH + 32'h1;
         else               a = BASE + {24'd0, 6'($urandom_range(0, 63)), 2'b00};
         xfer(a, 1'($urandom_range(0, 2) != 0), $urandom, 4'($urandom),
              int'($urandom_range(0, 2)), 1'b0, "rand_xfer");
      end
      rand_cap = 1'b0;
      tick();
      user_data_valid = 1'b0;

      do_reset();
      tick();
      user_data_valid = 1'b1;
      repeat (65535) begin
         @(negedge clk);
         user_data_in = $urandom;
      end
      user_data_valid = 1'b0;
      rd(2'd1, "status_cnt_ffff");
      cap(32'hCAFEF00D);
      rd(2'd1, "status_cnt_wrap");
      rd(2'd0, "data_after_wrap");

      tick();
      OPB_ABus = BASE; OPB_RNW = 1'b1; OPB_select = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      tick();
      OPB_select = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      rd(2'd0, "post_rst_data"); rd(2'd1, "post_rst_status"); rd(2'd2, "post_rst_ctrl");

      repeat (3) tick();
      end_req = 1'b1;
   end

endmodule
